// File: rtl/capture_readout.sv
`default_nettype none
// ============================================================================
// Module   : capture_readout
// Purpose  : Ring-buffer sink for the capture sample stream. After capture it
//            drains the ring oldest-first on an AXI-stream master.
// Revision : 1.0 - initial release
// ============================================================================
module capture_readout #(
   parameter int size    = 32,
   parameter int saddr_w = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [size-1:0]    s_tdata,
   input  logic               s_tvalid,
   output logic               s_tready,
   input  logic [saddr_w-1:0] buffer_size,
   input  logic               arm,
   input  logic               capture_done,
   input  logic               start,
   input  logic               abort,
   output logic [size-1:0]    m_tdata,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               m_tlast,
   output logic               wrapped,
   output logic [saddr_w-1:0] sample_count,
   output logic               busy
);
   localparam int               c_depth = 2**saddr_w;
   localparam logic [saddr_w-1:0] c_one = saddr_w'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [size-1:0]    r_mem [0:c_depth-1];
   logic [saddr_w-1:0] r_len, r_wptr, r_rptr, r_remaining;
   logic               r_wrapped;
   logic [size-1:0]    r_rdata, r_skid_data, r_out_data;
   logic               r_rd_pend, r_rd_last;
   logic               r_skid_valid, r_skid_last;
   logic               r_out_valid, r_out_last;

   logic               w_write, w_issue, w_out_free, w_last_hs, w_start_ok;
   logic [saddr_w-1:0] w_rd_addr, w_rd_rem, w_count;

   assign w_count    = r_wrapped ? r_len : r_wptr;
   assign w_out_free = !r_out_valid || m_tready;
   assign w_last_hs  = r_out_valid && m_tready && r_out_last;
   assign w_start_ok = (r_state == HOLD) && start && !arm && (w_count != '0);
   assign w_write    = (r_state == FILL) && s_tvalid;

   // A read is only issued when its data is guaranteed a landing slot next
   // cycle (output register or the empty skid register).
   always_comb begin
      w_issue   = 1'b0;
      w_rd_addr = r_rptr;
      w_rd_rem  = r_remaining;
      if (!abort) begin
         if (w_start_ok) begin
            w_issue   = 1'b1;
            w_rd_addr = r_wrapped ? r_wptr : '0;
            w_rd_rem  = w_count;
         end else if ((r_state == DRAIN) && (r_remaining != '0) && !r_skid_valid &&
                      !(r_rd_pend && !w_out_free)) begin
            w_issue = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (arm) w_state_nxt = FILL;
            FILL:    if (arm) w_state_nxt = FILL;
                     else if (capture_done) w_state_nxt = HOLD;
            HOLD:    if (arm) w_state_nxt = FILL;
                     else if (w_start_ok) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_hs) w_state_nxt = HOLD;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_write) r_mem[r_wptr] <= s_tdata;
      if (w_issue) r_rdata <= r_mem[w_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_wptr       <= '0;
         r_wrapped    <= 1'b0;
         r_rptr       <= '0;
         r_remaining  <= '0;
         r_rd_pend    <= 1'b0;
         r_rd_last    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_last  <= 1'b0;
         r_skid_data  <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_data   <= '0;
      end else begin
         r_state <= w_state_nxt;

         // A beat accepted in the abort cycle is still stored.
         if (!abort && arm && (r_state != DRAIN)) begin
            r_len     <= buffer_size;
            r_wptr    <= '0;
            r_wrapped <= 1'b0;
         end else if (w_write) begin
            if (r_wptr == r_len - c_one) begin
               r_wptr    <= '0;
               r_wrapped <= 1'b1;
            end else begin
               r_wptr <= r_wptr + c_one;
            end
         end

         r_rd_pend <= w_issue;
         if (w_issue) begin
            r_rptr      <= (w_rd_addr == r_len - c_one) ? '0 : w_rd_addr + c_one;
            r_remaining <= w_rd_rem - c_one;
            r_rd_last   <= (w_rd_rem == c_one);
         end

         if (abort || (r_state != DRAIN)) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
         end else if (w_out_free) begin
            if (r_skid_valid) begin
               r_out_valid  <= 1'b1;
               r_out_data   <= r_skid_data;
               r_out_last   <= r_skid_last;
               r_skid_valid <= r_rd_pend;
               r_skid_data  <= r_rdata;
               r_skid_last  <= r_rd_last;
            end else if (r_rd_pend) begin
               r_out_valid <= 1'b1;
               r_out_data  <= r_rdata;
               r_out_last  <= r_rd_last;
            end else begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end
         end else if (r_rd_pend) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= r_rdata;
            r_skid_last  <= r_rd_last;
         end
      end
   end

   assign s_tready     = (r_state == FILL);
   assign busy         = (r_state != IDLE);
   assign m_tdata      = r_out_data;
   assign m_tvalid     = r_out_valid;
   assign m_tlast      = r_out_last;
   assign wrapped      = r_wrapped;
   assign sample_count = w_count;

endmodule
`default_nettype wire
